div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Issue-side controller for the iterative divide/remainder unit (`divu_remu`).
- Accepts one DIV/DIVU/REM/REMU op at a time from the execute stage. Sequences the order/accepted/done handshake with the divider, and returns the result with its destination tag over a valid/ready writeback port.
- Resolves RISC-V special cases (divide by zero, signed overflow) without engaging the divider.
- Replays a repeated identical op from a one-entry memo.

Parameters:
- LEN_WORD, 32, operand/result width.
- TAG_W, 5, destination register tag width.
- MEMO_EN, 1, 1 enables the last-result memo; 0 means never hit.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  op request
- req_ready  out  1  controller can accept (IDLE only)
- req_rs1  in  LEN_WORD  dividend
- req_rs2  in  LEN_WORD  divisor
- req_unsig  in  1  1 = DIVU/REMU
- req_rem  in  1  1 = remainder, 0 = quotient
- req_tag  in  TAG_W  destination tag
- flush  in  1  pipeline kill; discards current op
- div_order  out  1  order to divider
- div_accepted  in  1  divider took order
- div_done  in  1  divider result valid this cycle
- div_rs1  out  LEN_WORD  latched dividend
- div_rs2  out  LEN_WORD  latched divisor
- div_unsig  out  1  latched signedness
- div_rem  out  1  latched quotient/remainder select
- div_rd  in  LEN_WORD  divider result, sampled when div_done=1
- wb_valid  out  1  result available
- wb_ready  in  1  writeback consumer ready
- wb_data  out  LEN_WORD  result
- wb_tag  out  TAG_W  destination tag

Behaviour:
- Reset (rstn=0, async):
  - State IDLE.
  - div_order=0, wb_valid=0.
  - wb_data, wb_tag and div_* operand registers = 0.
  - Memo invalid.
  - req_ready=1 after reset release.
- Transfer occurs when req_valid & req_ready. Operands and tag are latched into holding registers. div_rs1/div_rs2/div_unsig/div_rem drive from those registers and stay stable from latch until leaving WAIT.
- Classification at transfer, in priority order:
  - rs2==0: special. Quotient = all ones; remainder = rs1.
  - !unsig & rs1==0x80000000 & rs2==0xFFFFFFFF: special. Quotient = 0x80000000; remainder = 0.
  - MEMO_EN & memo valid & {rs1,rs2,unsig,rem} equal to memo key: hit, result = memo data.
  - Otherwise: normal.
- States:
  - IDLE: req_ready=1. On transfer go to RESP if special/hit (result loaded into wb_data the same edge; wb_valid=1 next cycle, i.e. 1-cycle latency). Otherwise go to ISSUE.
  - ISSUE: div_order=1. When div_accepted=1, go to WAIT. div_order drops the following cycle.
  - WAIT: div_order=0. When div_done=1, capture div_rd into wb_data, update memo key/data, set memo valid, go to RESP.
  - RESP: wb_valid=1. wb_data/wb_tag are held until wb_ready=1, then go to IDLE. A new request is accepted the cycle after, never the same cycle.
  - DRAIN: div_order=0, wb_valid=0. When div_done=1, update the memo with the result (operands are valid) and go to IDLE without writeback.
- flush handling:
  - In IDLE: suppresses transfer that cycle (req_ready forced 0).
  - In ISSUE with div_accepted=0: go to IDLE; order withdrawn next cycle.
  - In ISSUE with div_accepted=1, or in WAIT with div_done=0: go to DRAIN.
  - In WAIT with div_done=1: memo updated, go to IDLE, no writeback.
  - In RESP: wb_valid drops next cycle, go to IDLE.
- Memo:
  - Single entry.
  - Never updated from special-case results.
  - Retained across flush.
  - Cleared only by reset.
- Invariants:
  - div_order is never asserted outside ISSUE.
  - At most one op is outstanding in the divider.
  - wb_valid=1 implies no divider op is in flight.
  - A div_done arriving in IDLE/RESP is ignored (protocol violation, assertion in bench).

Test Plan:
- Normal DIVU: rs1=100, rs2=7, unsig=1, rem=0, tag=3; divider model done 5 cycles after accept -> one order pulse; wb_valid with wb_data=14, wb_tag=3; req_ready low until the cycle after the wb handshake.
- Divide by zero: REM rs1=0x12345678, rs2=0 -> div_order never asserted; wb_valid the cycle after transfer with wb_data=0x12345678. Same with DIV -> 0xFFFFFFFF.
- Signed overflow: DIV rs1=0x80000000, rs2=0xFFFFFFFF, unsig=0 -> wb_data=0x80000000, no order. REM on the same operands -> 0.
- Memo: REMU 100,7 then identical REMU 100,7 -> second completes in 1 cycle, wb_data=2, no order. DIVU 100,7 afterwards -> miss, divider used.
- Flush in WAIT: flush 2 cycles after accept -> no wb_valid; order stays low; state returns to IDLE only after div_done; next request issues normally; repeating the flushed op hits the memo.
- Backpressure and reset: hold wb_ready=0 for 10 cycles -> wb_data/wb_tag stable, req_ready=0. Assert rstn=0 mid-WAIT -> all outputs 0 immediately; memo miss afterwards.

Source files
------------

// File: rtl/div_sched.sv
// Issue-side controller for the iterative divider: accepts one DIV/REM op,
// short-circuits RISC-V special cases and memo hits, and writes back over valid/ready.
module div_sched #(
    parameter int LEN_WORD = 32,
    parameter int TAG_W    = 5,
    parameter int MEMO_EN  = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [LEN_WORD-1:0] req_rs1,
    input  logic [LEN_WORD-1:0] req_rs2,
    input  logic                req_unsig,
    input  logic                req_rem,
    input  logic [TAG_W-1:0]    req_tag,
    input  logic                flush,
    output logic                div_order,
    input  logic                div_accepted,
    input  logic                div_done,
    output logic [LEN_WORD-1:0] div_rs1,
    output logic [LEN_WORD-1:0] div_rs2,
    output logic                div_unsig,
    output logic                div_rem,
    input  logic [LEN_WORD-1:0] div_rd,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [LEN_WORD-1:0] wb_data,
    output logic [TAG_W-1:0]    wb_tag
);

    // state | meaning
    // IDLE  | ready for a new op
    // ISSUE | order raised, waiting for div_accepted
    // WAIT  | op in divider, waiting for div_done
    // RESP  | result held on writeback port until wb_ready
    // DRAIN | flushed op still in divider; absorb its div_done, no writeback
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic                MEMO_ON = (MEMO_EN != 0);
    localparam logic [LEN_WORD-1:0] MIN_NEG = {1'b1, {(LEN_WORD-1){1'b0}}};

    state_t              state_q, state_d;
    logic [LEN_WORD-1:0] rs1_q, rs1_d;
    logic [LEN_WORD-1:0] rs2_q, rs2_d;
    logic                unsig_q, unsig_d;
    logic                rem_q, rem_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [LEN_WORD-1:0] wb_data_q, wb_data_d;

    logic                memo_valid_q, memo_valid_d;
    logic [LEN_WORD-1:0] memo_rs1_q, memo_rs1_d;
    logic [LEN_WORD-1:0] memo_rs2_q, memo_rs2_d;
    logic                memo_unsig_q, memo_unsig_d;
    logic                memo_rem_q, memo_rem_d;
    logic [LEN_WORD-1:0] memo_data_q, memo_data_d;

    logic                div_by_zero;
    logic                sgn_ovf;
    logic                memo_hit;
    logic                fast_path;
    logic [LEN_WORD-1:0] fast_data;
    logic                memo_load;

    // Classification of the incoming request; special cases win over the memo.
    always_comb begin
        div_by_zero = (req_rs2 == '0);
        sgn_ovf     = !req_unsig && (req_rs1 == MIN_NEG) && (req_rs2 == '1);
        memo_hit    = MEMO_ON && memo_valid_q
                      && (req_rs1 == memo_rs1_q) && (req_rs2 == memo_rs2_q)
                      && (req_unsig == memo_unsig_q) && (req_rem == memo_rem_q);
        fast_path   = div_by_zero || sgn_ovf || memo_hit;
        if (div_by_zero) begin
            fast_data = req_rem ? req_rs1 : '1;
        end else if (sgn_ovf) begin
            fast_data = req_rem ? '0 : MIN_NEG;
        end else begin
            fast_data = memo_data_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        unsig_d      = unsig_q;
        rem_d        = rem_q;
        tag_d        = tag_q;
        wb_data_d    = wb_data_q;
        memo_valid_d = memo_valid_q;
        memo_rs1_d   = memo_rs1_q;
        memo_rs2_d   = memo_rs2_q;
        memo_unsig_d = memo_unsig_q;
        memo_rem_d   = memo_rem_q;
        memo_data_d  = memo_data_q;
        memo_load    = 1'b0;
        req_ready    = 1'b0;
        div_order    = 1'b0;
        wb_valid     = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    unsig_d = req_unsig;
                    rem_d   = req_rem;
                    tag_d   = req_tag;
                    if (fast_path) begin
                        wb_data_d = fast_data;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                div_order = 1'b1;
                if (flush) begin
                    state_d = div_accepted ? S_DRAIN : S_IDLE;
                end else if (div_accepted) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_done) begin
                    memo_load = 1'b1;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        wb_data_d = div_rd;
                        state_d   = S_RESP;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: begin
                wb_valid = 1'b1;
                if (flush || wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_done) begin
                    memo_load = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flushed op's result is still correct for its operands, so it may seed the memo.
        if (memo_load) begin
            memo_valid_d = 1'b1;
            memo_rs1_d   = rs1_q;
            memo_rs2_d   = rs2_q;
            memo_unsig_d = unsig_q;
            memo_rem_d   = rem_q;
            memo_data_d  = div_rd;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            unsig_q      <= 1'b0;
            rem_q        <= 1'b0;
            tag_q        <= '0;
            wb_data_q    <= '0;
            memo_valid_q <= 1'b0;
            memo_rs1_q   <= '0;
            memo_rs2_q   <= '0;
            memo_unsig_q <= 1'b0;
            memo_rem_q   <= 1'b0;
            memo_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            unsig_q      <= unsig_d;
            rem_q        <= rem_d;
            tag_q        <= tag_d;
            wb_data_q    <= wb_data_d;
            memo_valid_q <= memo_valid_d;
            memo_rs1_q   <= memo_rs1_d;
            memo_rs2_q   <= memo_rs2_d;
            memo_unsig_q <= memo_unsig_d;
            memo_rem_q   <= memo_rem_d;
            memo_data_q  <= memo_data_d;
        end
    end

    assign div_rs1   = rs1_q;
    assign div_rs2   = rs2_q;
    assign div_unsig = unsig_q;
    assign div_rem   = rem_q;
    assign wb_data   = wb_data_q;
    assign wb_tag    = tag_q;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched with a behavioural divider answering 5 cycles after accept.
module tb_div_sched;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic        req_unsig = 1'b0;
    logic        req_rem = 1'b0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        div_order;
    logic        div_accepted = 1'b0;
    logic        div_done = 1'b0;
    logic [31:0] div_rs1, div_rs2;
    logic        div_unsig, div_rem;
    logic [31:0] div_rd = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [36:0] exp_q[$];
    int          order_cnt = 0;
    logic        dbusy = 1'b0;
    int          dcnt = 0;
    logic [31:0] dres = '0;

    div_sched dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_unsig(req_unsig),
        .req_rem(req_rem), .req_tag(req_tag), .flush(flush),
        .div_order(div_order), .div_accepted(div_accepted), .div_done(div_done),
        .div_rs1(div_rs1), .div_rs2(div_rs2), .div_unsig(div_unsig), .div_rem(div_rem),
        .div_rd(div_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic u, input logic r);
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
        if (u) return r ? (a % b) : (a / b);
        return r ? $unsigned($signed(a) % $signed(b)) : $unsigned($signed(a) / $signed(b));
    endfunction

    // Divider model: accepts an order immediately, completes 5 cycles later.
    initial forever begin
        @(negedge clk); #1;
        if (!rstn) begin
            dbusy = 1'b0; dcnt = 0; div_accepted = 1'b0; div_done = 1'b0;
        end else begin
            div_done = 1'b0;
            if (dbusy && dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    div_done = 1'b1;
                    div_rd   = dres;
                    dbusy    = 1'b0;
                end
            end
            if (div_order && !dbusy) begin
                div_accepted = 1'b1;
                dbusy = 1'b1;
                dcnt  = 5;
                dres  = ref_div(div_rs1, div_rs2, div_unsig, div_rem);
                order_cnt++;
            end else begin
                div_accepted = 1'b0;
            end
        end
    end

    // Writeback monitor: pops the scoreboard on every handshake.
    initial forever begin
        logic [36:0] ex;
        @(negedge clk); #2;
        if (rstn && wb_valid) begin
            check("rdy_low_in_resp", req_ready, 0);
            check("no_order_in_resp", div_order, 0);
            if (wb_ready) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    ex = exp_q.pop_front();
                    check("wb_data", wb_data, ex[31:0]);
                    check("wb_tag", wb_tag, ex[36:32]);
                end
            end
        end
    end

    // mode 0: divider op, 1: one-cycle result expected, 2: op will be killed (no expectation)
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic u,
                        input logic r, input logic [4:0] t, input int mode);
        int n;
        req_rs1 = a; req_rs2 = b; req_unsig = u; req_rem = r; req_tag = t;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_timeout", 0, 1);
        if (mode != 2) exp_q.push_back({t, ref_div(a, b, u, r)});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (mode == 1) check("fast_wb_valid", wb_valid, 1);
        else check("busy_req_ready", req_ready, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(req_ready && !wb_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (req_ready && !wb_valid), 1);
    endtask

    task automatic wait_accept(input int oc);
        int n;
        n = 0;
        while (order_cnt == oc && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", order_cnt, oc + 1);
    endtask

    initial begin
        int oc;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_div_order", div_order, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_tag", wb_tag, 0);
        check("rst_div_rs1", div_rs1, 0);

        oc = order_cnt;
        send(32'd100, 32'd7, 1, 0, 5'd3, 0);
        wait_idle();
        check("divu_orders", order_cnt, oc + 1);

        oc = order_cnt;
        send(32'h1234_5678, 32'd0, 0, 1, 5'd4, 1);
        send(32'h1234_5678, 32'd0, 0, 0, 5'd5, 1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 5'd6, 1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 5'd7, 1);
        wait_idle();
        check("special_no_order", order_cnt, oc);

        oc = order_cnt;
        send(32'd100, 32'd7, 1, 1, 5'd8, 0);
        wait_idle();
        send(32'd100, 32'd7, 1, 1, 5'd9, 1);
        wait_idle();
        check("memo_hit_orders", order_cnt, oc + 1);
        send(32'd100, 32'd7, 1, 0, 5'd10, 0);
        wait_idle();
        check("memo_miss_orders", order_cnt, oc + 2);

        oc = order_cnt;
        send(32'd1000, 32'd9, 1, 0, 5'd11, 2);
        wait_accept(oc);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("drain_req_ready", req_ready, 0);
        check("drain_order", div_order, 0);
        check("drain_div_busy", dbusy, 1);
        wait_idle();
        check("drain_done_seen", dbusy, 0);
        send(32'd1000, 32'd9, 1, 0, 5'd12, 1);
        wait_idle();
        check("flush_memo_orders", order_cnt, oc + 1);
        send(32'hFFFF_FF9C, 32'd7, 0, 0, 5'd13, 0);
        wait_idle();
        check("post_flush_orders", order_cnt, oc + 2);

        wb_ready = 1'b0;
        send(32'd50, 32'd5, 1, 0, 5'd14, 0);
        begin
            int n;
            n = 0;
            while (!wb_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_wb_valid", wb_valid, 1);
            check("bp_wb_data", wb_data, 32'd10);
            check("bp_wb_tag", wb_tag, 5'd14);
            check("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        wait_idle();

        oc = order_cnt;
        send(32'd77, 32'd7, 1, 0, 5'd15, 2);
        wait_accept(oc);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #3;
        check("mid_rst_order", div_order, 0);
        check("mid_rst_wb_valid", wb_valid, 0);
        check("mid_rst_wb_data", wb_data, 0);
        check("mid_rst_wb_tag", wb_tag, 0);
        check("mid_rst_div_rs1", div_rs1, 0);
        check("mid_rst_div_rs2", div_rs2, 0);
        check("mid_rst_div_unsig", div_unsig, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        oc = order_cnt;
        send(32'd77, 32'd7, 1, 0, 5'd16, 0);
        wait_idle();
        check("post_rst_memo_miss", order_cnt, oc + 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
